// File: rtl/mips_wb_arbiter.sv
// Round-robin write-back arbiter driving the single register-file write port.
// Define MIPS_WB_INIT_CLEAR_EN to add the post-reset r1..r31 zero sweep (INIT state).
module mips_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [5*N_REQ-1:0]    reqAddr,
    input  logic [32*N_REQ-1:0]   reqData,
    output logic [N_REQ-1:0]      ack,
    output logic                  wEn,
    output logic [4:0]            addrW,
    output logic [31:0]           BusW,
    output logic                  busy
);

    // Handshake: a requester holds req/reqAddr/reqData stable until it sees ack
    // in the same cycle; the accepted write appears on wEn/addrW/BusW one cycle later.

    logic             wen_q,  wen_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [PTR_W-1:0] ptr_q,  ptr_d;

    logic             in_init;
    logic             run_ok;
    logic             grant_found;
    int               win_i;
    logic             grant_valid;

`ifdef MIPS_WB_INIT_CLEAR_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic       busy_q, busy_d;

    assign in_init = (state_q == ST_INIT);
    assign busy    = busy_q;
`else
    assign in_init = 1'b0;
    assign busy    = 1'b0;
`endif

    // ack is forced low during reset so nothing is accepted that would be discarded.
    assign run_ok = rst_n & ~in_init;

    always_comb begin
        grant_found = 1'b0;
        win_i       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                win_i       = idx;
            end
        end
    end

    assign grant_valid = grant_found & run_ok;

    always_comb begin
        ack = '0;
        if (grant_valid) begin
            ack[win_i] = 1'b1;
        end
    end

    always_comb begin
        wen_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        ptr_d  = ptr_q;
`ifdef MIPS_WB_INIT_CLEAR_EN
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
`endif
        if (in_init) begin
`ifdef MIPS_WB_INIT_CLEAR_EN
            wen_d  = 1'b1;
            addr_d = clr_idx_q;
            data_d = 32'd0;
            // busy drops on the same edge that issues the r31 clear.
            if (clr_idx_q == 5'd31) begin
                state_d = ST_RUN;
                busy_d  = 1'b0;
            end else begin
                clr_idx_d = clr_idx_q + 5'd1;
            end
`endif
        end else if (grant_valid) begin
            addr_d = reqAddr[win_i*5 +: 5];
            data_d = reqData[win_i*32 +: 32];
            wen_d  = (reqAddr[win_i*5 +: 5] != 5'd0);
            ptr_d  = PTR_W'((win_i + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
            ptr_q  <= '0;
`ifdef MIPS_WB_INIT_CLEAR_EN
            state_q   <= ST_INIT;
            clr_idx_q <= 5'd1;
            busy_q    <= 1'b1;
`endif
        end else begin
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
`ifdef MIPS_WB_INIT_CLEAR_EN
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
`endif
        end
    end

    assign wEn   = wen_q;
    assign addrW = addr_q;
    assign BusW  = data_q;

endmodule
